std_cache_vldrty_store: RTL and testbench

- Parametrised valid/dirty state store for the non-blocking L1 dcache.
- Replaces the byte-aligned valid/dirty SRAM workaround: flop-based, per-way bit enables, no 4x padding.
- Adds a hardware invalidate-all sweep and a running dirty-line counter. The miss handler uses the counter to skip flush write-back when nothing is dirty.
- Sits between the tag-compare arbiter output and the data/tag SRAMs; exposes an SRAM-like port.

---
 rtl/std_cache_pkg.sv | 15 +
 rtl/std_cache_vldrty_store_popcount.sv | 21 ++
 rtl/std_cache_vldrty_store.sv | 142 ++++++++++++++
 tb/tb_std_cache_vldrty_store.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/std_cache_pkg.sv
// Shared types for the L1 dcache valid/dirty state store.
package std_cache_pkg;

  typedef struct packed {
    logic valid;
    logic dirty;
  } vldrty_t;

  typedef enum logic [1:0] {
    INV_IDLE,
    INV_SWEEP,
    INV_ACK
  } inv_state_e;

endpackage

// File: rtl/std_cache_vldrty_store_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module std_cache_vldrty_store_popcount
  import std_cache_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // NOTE: blocking '=' is correct inside always_comb; the running sum must
  // see its own previous iteration within the same evaluation.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/std_cache_vldrty_store.sv
// Flop-based valid/dirty store for the L1 dcache with an invalidate-all
// sweep and a running count of dirty (set, way) entries.
module std_cache_vldrty_store
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_WAYS = 8,
  parameter int unsigned NR_SETS = 256,
  parameter int unsigned IDX_W   = $clog2(NR_SETS),
  parameter int unsigned CNT_W   = $clog2(NR_SETS * NR_WAYS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NR_WAYS-1:0] req_i,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   addr_i,
  input  logic [NR_WAYS-1:0] valid_i,
  input  logic [NR_WAYS-1:0] dirty_i,
  input  logic [NR_WAYS-1:0] be_i,
  output logic               gnt_o,
  output logic [NR_WAYS-1:0] valid_o,
  output logic [NR_WAYS-1:0] dirty_o,
  input  logic               inv_req_i,
  output logic               inv_ack_o,
  output logic [CNT_W-1:0]   dirty_cnt_o,
  output logic               dirty_any_o
);

  localparam int unsigned PC_W = $clog2(NR_WAYS + 1);
  localparam int unsigned PAD  = CNT_W + 1 - PC_W;

  vldrty_t [NR_WAYS-1:0] mem_q [NR_SETS];
  inv_state_e            state_q, state_d;
  logic [IDX_W-1:0]      sweep_q;
  logic [NR_WAYS-1:0]    rd_valid_q, rd_dirty_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  sweeping, do_write, do_read;
  logic [IDX_W-1:0]      old_addr;
  logic [NR_WAYS-1:0]    old_mask, old_dirty;
  logic [PC_W-1:0]       pc_new, pc_old;
  logic signed [CNT_W:0] cnt_s, new_s, old_s, cnt_next;

  assign sweeping = (state_q == INV_SWEEP);
  assign gnt_o    = (|req_i) & (state_q == INV_IDLE) & ~inv_req_i;
  assign do_write = gnt_o & we_i;
  assign do_read  = gnt_o & ~we_i;

  // The sweep borrows the "old" popcount path, counting every way of the
  // set being cleared.
  assign old_addr = sweeping ? sweep_q : addr_i;
  assign old_mask = sweeping ? '1 : be_i;

  always_comb begin
    old_dirty = '0;
    for (int w = 0; w < NR_WAYS; w++) begin
      old_dirty[w] = mem_q[old_addr][w].dirty;
    end
  end

  std_cache_vldrty_store_popcount #(.WIDTH(NR_WAYS), .CNT_W(PC_W)) u_pc_new (
    .data  (dirty_i & be_i),
    .count (pc_new)
  );

  std_cache_vldrty_store_popcount #(.WIDTH(NR_WAYS), .CNT_W(PC_W)) u_pc_old (
    .data  (old_dirty & old_mask),
    .count (pc_old)
  );

  assign cnt_s = $signed({1'b0, cnt_q});
  assign new_s = $signed({{PAD{1'b0}}, pc_new});
  assign old_s = $signed({{PAD{1'b0}}, pc_old});

  // NOTE: every branch-assigned signal gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_next = cnt_s;
    if (sweeping) begin
      cnt_next = cnt_s - old_s;
    end else if (do_write) begin
      cnt_next = cnt_s + new_s - old_s;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INV_IDLE:  if (inv_req_i) state_d = INV_SWEEP;
      INV_SWEEP: if (sweep_q == IDX_W'(NR_SETS - 1)) state_d = INV_ACK;
      INV_ACK:   state_d = INV_IDLE;
      default:   state_d = INV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INV_IDLE;
      sweep_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweeping ? sweep_q + IDX_W'(1) : '0;
      cnt_q   <= cnt_next[CNT_W-1:0];
    end
  end

  // NOTE: this array is deliberately reset; a cold cache must see every line
  // invalid, so it cannot be left to power-up contents like a real SRAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NR_SETS; s++) begin
        mem_q[s] <= '0;
      end
    end else if (sweeping) begin
      mem_q[sweep_q] <= '0;
    end else if (do_write) begin
      for (int w = 0; w < NR_WAYS; w++) begin
        if (be_i[w]) mem_q[addr_i][w] <= vldrty_t'{valid: valid_i[w], dirty: dirty_i[w]};
      end
    end
  end

  // Read data only moves on granted reads, so it holds through writes and sweeps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= '0;
      rd_dirty_q <= '0;
    end else if (do_read) begin
      for (int w = 0; w < NR_WAYS; w++) begin
        rd_valid_q[w] <= mem_q[addr_i][w].valid;
        rd_dirty_q[w] <= mem_q[addr_i][w].dirty;
      end
    end
  end

  assign valid_o     = rd_valid_q;
  assign dirty_o     = rd_dirty_q;
  assign inv_ack_o   = (state_q == INV_ACK);
  assign dirty_cnt_o = cnt_q;
  assign dirty_any_o = |cnt_q;

endmodule

// File: tb/tb_std_cache_vldrty_store.sv
// Directed bench for the valid/dirty store: access, dirty counting, sweep, reset.
module tb_std_cache_vldrty_store;

  localparam int NR_WAYS = 8;
  localparam int NR_SETS = 256;
  localparam int IDX_W   = 8;
  localparam int CNT_W   = 12;

  logic               clk;
  logic               rst_n;
  logic [NR_WAYS-1:0] req, valid_in, dirty_in, be;
  logic               we;
  logic [IDX_W-1:0]   addr;
  logic               gnt;
  logic [NR_WAYS-1:0] valid_out, dirty_out;
  logic               inv_req, inv_ack;
  logic [CNT_W-1:0]   dirty_cnt;
  logic               dirty_any;

  int n_checks = 0;
  int n_errors = 0;

  std_cache_vldrty_store #(.NR_WAYS(NR_WAYS), .NR_SETS(NR_SETS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .valid_i     (valid_in),
    .dirty_i     (dirty_in),
    .be_i        (be),
    .gnt_o       (gnt),
    .valid_o     (valid_out),
    .dirty_o     (dirty_out),
    .inv_req_i   (inv_req),
    .inv_ack_o   (inv_ack),
    .dirty_cnt_o (dirty_cnt),
    .dirty_any_o (dirty_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic rd(input logic [IDX_W-1:0] a);
    req = '1; we = 1'b0; addr = a;
    #1 check("gnt_rd", 32'(gnt), 32'd1);
    @(negedge clk);
    req = '0;
  endtask

  task automatic wr(input logic [IDX_W-1:0] a, input logic [7:0] b,
                    input logic [7:0] v, input logic [7:0] d);
    req = '1; we = 1'b1; addr = a; be = b; valid_in = v; dirty_in = d;
    #1 check("gnt_wr", 32'(gnt), 32'd1);
    @(negedge clk);
    req = '0; we = 1'b0; be = '0;
  endtask

  // Holds inv_req until ack, returning the falling-edge index of the ack.
  task automatic wait_ack(output int cycles);
    cycles = -1;
    for (int k = 0; k < NR_SETS + 10; k++) begin
      #1;
      if (inv_ack) begin
        cycles = k;
        break;
      end
      @(negedge clk);
    end
    inv_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n_gnt_low, n_ack, ack_k, hold_err, rd_err, late_ack;
    int cnt_at_ack;

    rst_n = 1'b0; req = '0; we = 1'b0; addr = '0;
    valid_in = '0; dirty_in = '0; be = '0; inv_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ack", 32'(inv_ack), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_dirty", 32'(dirty_out), 0);
    check("rst_cnt", 32'(dirty_cnt), 0);
    check("rst_any", 32'(dirty_any), 0);
    rst_n = 1'b1;
    @(negedge clk);

    rd(8'd5);
    check("rd5_valid", 32'(valid_out), 0);
    check("rd5_dirty", 32'(dirty_out), 0);
    check("rd5_cnt", 32'(dirty_cnt), 0);

    wr(8'd3, 8'h05, 8'hFF, 8'h01);
    check("wr3_cnt", 32'(dirty_cnt), 1);
    check("wr3_any", 32'(dirty_any), 1);
    check("wr3_rdata_held", 32'(valid_out), 0);
    rd(8'd3);
    check("rd3_valid", 32'(valid_out), 32'h05);
    check("rd3_dirty", 32'(dirty_out), 32'h01);

    wr(8'd3, 8'h01, 8'hFF, 8'h00);
    check("ow3_cnt", 32'(dirty_cnt), 0);
    check("ow3_any", 32'(dirty_any), 0);
    rd(8'd3);
    check("ow3_valid", 32'(valid_out), 32'h05);
    check("ow3_dirty", 32'(dirty_out), 32'h00);

    wr(8'd0, 8'h0F, 8'h0F, 8'h0F);
    check("wr0_rdata_held", 32'(valid_out), 32'h05);
    wr(8'(NR_SETS - 1), 8'hF0, 8'hF0, 8'hF0);
    check("two_sets_cnt", 32'(dirty_cnt), 8);
    rd(8'(NR_SETS - 1));
    check("rd_last_valid", 32'(valid_out), 32'hF0);

    // Invalidate-all sweep, with a read request held high throughout.
    inv_req = 1'b1; req = '1; we = 1'b0; addr = 8'(NR_SETS - 1);
    n_gnt_low = 0; n_ack = 0; ack_k = -1; hold_err = 0; cnt_at_ack = -1;
    for (int k = 0; k < NR_SETS + 4; k++) begin
      #1;
      if (!gnt) n_gnt_low++;
      if (inv_ack) begin
        n_ack++;
        ack_k = k;
        cnt_at_ack = int'(dirty_cnt);
        inv_req = 1'b0;
      end
      if (k <= NR_SETS + 1 && (valid_out !== 8'hF0 || dirty_out !== 8'hF0)) hold_err++;
      if (k == 2) check("sweep_cnt_after_set0", 32'(dirty_cnt), 4);
      @(negedge clk);
    end
    req = '0; inv_req = 1'b0;
    check("sweep_gnt_low_cycles", 32'(n_gnt_low), 32'(NR_SETS + 2));
    check("sweep_ack_count", 32'(n_ack), 1);
    check("sweep_ack_cycle", 32'(ack_k), 32'(NR_SETS + 1));
    check("sweep_cnt_at_ack", 32'(cnt_at_ack), 0);
    check("sweep_rdata_hold_errs", 32'(hold_err), 0);
    rd(8'd0);
    check("swept0_valid", 32'(valid_out), 0);
    check("swept0_dirty", 32'(dirty_out), 0);
    rd(8'(NR_SETS - 1));
    check("swept_last_valid", 32'(valid_out), 0);
    check("swept_last_dirty", 32'(dirty_out), 0);

    // Invalidate wins over a simultaneous write.
    inv_req = 1'b1; req = '1; we = 1'b1; addr = 8'd7;
    be = '1; valid_in = '1; dirty_in = '1;
    #1 check("inv_vs_wr_gnt", 32'(gnt), 0);
    @(negedge clk);
    req = '0; we = 1'b0; be = '0;
    wait_ack(ack_k);
    check("inv_vs_wr_ack_cycle", 32'(ack_k), 32'(NR_SETS));
    check("inv_vs_wr_cnt", 32'(dirty_cnt), 0);
    rd(8'd7);
    check("set7_valid", 32'(valid_out), 0);
    check("set7_dirty", 32'(dirty_out), 0);

    // Reset in the middle of a sweep.
    wr(8'd20, 8'hFF, 8'hFF, 8'h3C);
    rd(8'd20);
    check("set20_valid", 32'(valid_out), 32'hFF);
    inv_req = 1'b1;
    repeat (11) @(negedge clk);
    check("midsweep_cnt", 32'(dirty_cnt), 4);
    rst_n = 1'b0; inv_req = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_ack", 32'(inv_ack), 0);
    check("midrst_valid", 32'(valid_out), 0);
    check("midrst_dirty", 32'(dirty_out), 0);
    check("midrst_cnt", 32'(dirty_cnt), 0);
    check("midrst_any", 32'(dirty_any), 0);
    @(negedge clk);
    rst_n = 1'b1;
    late_ack = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 if (inv_ack) late_ack++;
    end
    check("no_ack_after_rst", 32'(late_ack), 0);
    rd_err = 0;
    for (int s = 0; s < NR_SETS; s++) begin
      rd(8'(s));
      if (valid_out !== '0 || dirty_out !== '0) rd_err++;
    end
    check("all_sets_zero_errs", 32'(rd_err), 0);
    check("final_cnt", 32'(dirty_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
